// File: rtl/ntt_addr_gen.sv
// ---------------------------------------------------------------------------
// ntt_addr_gen
//
// Purpose:
//   Address / twiddle sequencer that sits right after the NTT controller.
//   A start pulse launches a walk over all LOGN stages of an in-place
//   N-point (N = 2^LOGN) negative-wrapped NTT. Each butterfly is emitted as
//   one (addr_a, addr_b, tw_idx) triple on a valid/ready handshake toward
//   the butterfly unit. Forward order is Cooley-Tukey (span halves per
//   stage, twiddle psi[m+i]).
//
// Optional feature (macro NTT_INV_EN):
//   When defined, an extra input 'inv' is latched on start acceptance and
//   selects Gentleman-Sande inverse order (span doubles per stage, twiddle
//   index (N>>(s+1)) + i). When undefined, only forward order exists and
//   there is no 'inv' port.
//
// Parameters:
//   LOGN       log2 of the polynomial length (>= 2)
//   STAGE_GAP  idle cycles between stages so the butterfly pipe drains (0 ok)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   one-cycle launch request, honoured only in IDLE
//   inv        in   (NTT_INV_EN only) 1 = inverse order, latched on start
//   busy       out  high while the sequence is running (RUN / GAP)
//   out_valid  out  current butterfly fields are valid
//   out_ready  in   butterfly unit accepts the current butterfly
//   addr_a     out  upper operand address j
//   addr_b     out  lower operand address j + t
//   tw_idx     out  twiddle ROM index
//   stage      out  current stage s
//   last       out  current butterfly is the final one of its stage
//   done       out  one-cycle pulse after the final butterfly is accepted
// ---------------------------------------------------------------------------
module ntt_addr_gen #(
    parameter int LOGN      = 8,
    parameter int STAGE_GAP = 4,
    localparam int SW       = $clog2(LOGN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
`ifdef NTT_INV_EN
    input  logic            inv,
`endif
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b,
    output logic [LOGN-1:0] tw_idx,
    output logic [SW-1:0]   stage,
    output logic            last,
    output logic            done
);

    // Gap counter needs at least one bit even when STAGE_GAP is 0 or 1.
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    localparam logic [LOGN-2:0] K_MAX   = '1;
    localparam logic [SW-1:0]   S_LAST  = SW'(LOGN - 1);
    localparam logic [GW-1:0]   G_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [LOGN-1:0] ONE_N   = LOGN'(1);
    localparam logic [LOGN-1:0] HALF_N  = ONE_N << (LOGN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Mode select
    // -----------------------------------------------------------------------
    logic inv_in;
`ifdef NTT_INV_EN
    assign inv_in = inv;
`else
    assign inv_in = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State and counters
    // -----------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [LOGN-2:0] k_q, k_d;
    logic [SW-1:0]   s_q, s_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            inv_q, inv_d;

    // Registered outputs and their next values
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [LOGN-1:0] addr_a_q, addr_a_d;
    logic [LOGN-1:0] addr_b_q, addr_b_d;
    logic [LOGN-1:0] tw_q, tw_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic            last_q, last_d;
    logic            done_q, done_d;

    // -----------------------------------------------------------------------
    // Process 1: state register (plus counters and output registers)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            s_q      <= '0;
            gap_q    <= '0;
            inv_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
            stage_q  <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            s_q      <= s_d;
            gap_q    <= gap_d;
            inv_q    <= inv_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
            stage_q  <= stage_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Process 2: next-state and counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        gap_d   = gap_q;
        inv_d   = inv_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    k_d     = '0;
                    s_d     = '0;
                    gap_d   = '0;
                    inv_d   = inv_in;
                end
            end

            ST_RUN: begin
                // out_valid is always high in RUN, so out_ready alone is
                // the handshake.
                if (out_ready) begin
                    if (k_q == K_MAX) begin
                        k_d = '0;
                        if (s_q == S_LAST) begin
                            state_d = ST_DONE;
                        end else if (STAGE_GAP == 0) begin
                            s_d = s_q + SW'(1);
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == G_LAST) begin
                    state_d = ST_RUN;
                    s_d     = s_q + SW'(1);
                    k_d     = '0;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                k_d     = '0;
                s_d     = '0;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Process 3: output logic
    //
    // Outputs are computed from the *next* state/counters and registered, so
    // the butterfly for the new (k, s) appears right after the edge that
    // produced it. On a stall k/s hold, so the outputs hold too.
    // -----------------------------------------------------------------------
    logic [SW-1:0]   lt;
    logic [LOGN-1:0] k_ext;
    logic [LOGN-1:0] span;
    logic [LOGN-1:0] grp;
    logic [LOGN-1:0] a_calc;
    logic [LOGN-1:0] tw_base;

    always_comb begin
        // Shift amount: forward spans shrink with s, inverse spans grow.
        lt      = inv_d ? s_d : (S_LAST - s_d);
        k_ext   = {1'b0, k_d};
        span    = ONE_N << lt;
        grp     = k_ext >> lt;
        // Group index moved above the span bit, offset within group below it.
        a_calc  = ((grp << lt) << 1) | (k_ext & (span - ONE_N));
        tw_base = inv_d ? (HALF_N >> s_d) : (ONE_N << s_d);

        busy_d   = (state_d == ST_RUN) || (state_d == ST_GAP);
        valid_d  = (state_d == ST_RUN);
        done_d   = (state_d == ST_DONE);
        addr_a_d = '0;
        addr_b_d = '0;
        tw_d     = '0;
        stage_d  = '0;
        last_d   = 1'b0;

        if (state_d == ST_RUN) begin
            addr_a_d = a_calc;
            // The span bit of a_calc is always clear, so this cannot carry out.
            addr_b_d = a_calc + span;
            tw_d     = tw_base + grp;
            stage_d  = s_d;
            last_d   = (k_d == K_MAX);
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign addr_a    = addr_a_q;
    assign addr_b    = addr_b_q;
    assign tw_idx    = tw_q;
    assign stage     = stage_q;
    assign last      = last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_ntt_addr_gen
//
// Directed bench for ntt_addr_gen at LOGN=3. Two instances share the clock:
// dut_a has STAGE_GAP=0, dut_b has STAGE_GAP=4. Inputs are driven and
// outputs sampled on the falling edge. Expected butterflies come from
// hand-computed tables.
// ---------------------------------------------------------------------------
module tb_ntt_addr_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // dut_a : STAGE_GAP = 0
    logic       start_a, ready_a, busy_a, valid_a, last_a, done_a;
    logic [2:0] a_a, b_a, tw_a;
    logic [1:0] st_a;
    // dut_b : STAGE_GAP = 4
    logic       start_b, ready_b, busy_b, valid_b, last_b, done_b;
    logic [2:0] a_b, b_b, tw_b;
    logic [1:0] st_b;
`ifdef NTT_INV_EN
    logic inv_a, inv_b;
`endif

    ntt_addr_gen #(.LOGN(3), .STAGE_GAP(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
`ifdef NTT_INV_EN
        .inv(inv_a),
`endif
        .busy(busy_a), .out_valid(valid_a), .out_ready(ready_a),
        .addr_a(a_a), .addr_b(b_a), .tw_idx(tw_a), .stage(st_a),
        .last(last_a), .done(done_a)
    );

    ntt_addr_gen #(.LOGN(3), .STAGE_GAP(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
`ifdef NTT_INV_EN
        .inv(inv_b),
`endif
        .busy(busy_b), .out_valid(valid_b), .out_ready(ready_b),
        .addr_a(a_b), .addr_b(b_b), .tw_idx(tw_b), .stage(st_b),
        .last(last_b), .done(done_b)
    );

    // Forward (Cooley-Tukey) butterfly order for N=8
    int fa[12]  = '{0, 1, 2, 3,  0, 1, 4, 5,  0, 2, 4, 6};
    int fb[12]  = '{4, 5, 6, 7,  2, 3, 6, 7,  1, 3, 5, 7};
    int ftw[12] = '{1, 1, 1, 1,  2, 2, 3, 3,  4, 5, 6, 7};
    // Inverse (Gentleman-Sande) order for N=8
    int ia[12]  = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int ib[12]  = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int itw[12] = '{4, 5, 6, 7,  2, 2, 3, 3,  1, 1, 1, 1};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Check one presented butterfly n against the forward or inverse table.
    task automatic chk_bf(input string tag, input int n, input bit use_inv,
                          input logic [2:0] a, input logic [2:0] b, input logic [2:0] tw,
                          input logic [1:0] st, input logic lst, input logic vld,
                          input logic bsy, input logic dn);
        int ea, eb, et;
        ea = use_inv ? ia[n]  : fa[n];
        eb = use_inv ? ib[n]  : fb[n];
        et = use_inv ? itw[n] : ftw[n];
        check($sformatf("%s[%0d].valid", tag, n), {31'd0, vld}, 32'd1);
        check($sformatf("%s[%0d].addr_a", tag, n), {29'd0, a}, ea);
        check($sformatf("%s[%0d].addr_b", tag, n), {29'd0, b}, eb);
        check($sformatf("%s[%0d].tw_idx", tag, n), {29'd0, tw}, et);
        check($sformatf("%s[%0d].stage", tag, n), {30'd0, st}, n / 4);
        check($sformatf("%s[%0d].last", tag, n), {31'd0, lst}, (n % 4 == 3) ? 32'd1 : 32'd0);
        check($sformatf("%s[%0d].busy", tag, n), {31'd0, bsy}, 32'd1);
        check($sformatf("%s[%0d].done", tag, n), {31'd0, dn}, 32'd0);
        $display("tb: %s bf %0d a=%0d b=%0d tw=%0d stage=%0d last=%0d",
                 tag, n, a, b, tw, st, lst);
    endtask

    task automatic chk_a(input string tag, input int n, input bit use_inv);
        chk_bf(tag, n, use_inv, a_a, b_a, tw_a, st_a, last_a, valid_a, busy_a, done_a);
    endtask

    task automatic chk_b(input string tag, input int n);
        chk_bf(tag, n, 1'b0, a_b, b_b, tw_b, st_b, last_b, valid_b, busy_b, done_b);
    endtask

    // All outputs of dut_a at zero (reset / idle)
    task automatic chk_zero_a(input string tag);
        check({tag, ".busy"},   {31'd0, busy_a},  32'd0);
        check({tag, ".valid"},  {31'd0, valid_a}, 32'd0);
        check({tag, ".done"},   {31'd0, done_a},  32'd0);
        check({tag, ".addr_a"}, {29'd0, a_a},     32'd0);
        check({tag, ".addr_b"}, {29'd0, b_a},     32'd0);
        check({tag, ".tw_idx"}, {29'd0, tw_a},    32'd0);
        check({tag, ".stage"},  {30'd0, st_a},    32'd0);
        check({tag, ".last"},   {31'd0, last_a},  32'd0);
        $display("tb: %s outputs checked for zero", tag);
    endtask

    initial begin
        rst     = 1'b0;
        start_a = 1'b1;
        start_b = 1'b1;
        ready_a = 1'b1;
        ready_b = 1'b1;
`ifdef NTT_INV_EN
        inv_a = 1'b0;
        inv_b = 1'b0;
`endif
        // ---- Reset held 5 cycles with start high: nothing may launch ----
        @(negedge clk);
        for (int r = 0; r < 5; r++) begin
            chk_zero_a($sformatf("rst_hold%0d", r));
            check($sformatf("rst_hold%0d.b_valid", r), {31'd0, valid_b}, 32'd0);
            check($sformatf("rst_hold%0d.b_busy", r),  {31'd0, busy_b},  32'd0);
            tick();
        end
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        tick();
        chk_zero_a("idle");

        // ---- Run 1: dut_a, STAGE_GAP=0, with a stray start at stage 1 ----
        start_a = 1'b1;
        tick();
        t0      = cyc;
        start_a = 1'b0;
        for (int n = 0; n < 12; n++) begin
            chk_a("run1", n, 1'b0);
            if (n == 5) start_a = 1'b1;
            tick();
            start_a = 1'b0;
        end
        check("run1.done", {31'd0, done_a}, 32'd1);
        check("run1.done_busy", {31'd0, busy_a}, 32'd0);
        check("run1.done_valid", {31'd0, valid_a}, 32'd0);
        check("run1.latency", cyc - t0 + 1, 32'd13);
        $display("tb: run1 done after %0d cycles", cyc - t0 + 1);
        for (int q = 0; q < 3; q++) begin
            tick();
            check($sformatf("run1.post%0d.done", q), {31'd0, done_a}, 32'd0);
            check($sformatf("run1.post%0d.valid", q), {31'd0, valid_a}, 32'd0);
        end

        // ---- Run 2: dut_b, STAGE_GAP=4 ----
        start_b = 1'b1;
        tick();
        t0      = cyc;
        start_b = 1'b0;
        for (int n = 0; n < 12; n++) begin
            chk_b("run2", n);
            tick();
            if (n == 3 || n == 7) begin
                for (int g = 0; g < 4; g++) begin
                    check($sformatf("run2.gap%0d_%0d.valid", n / 4, g), {31'd0, valid_b}, 32'd0);
                    check($sformatf("run2.gap%0d_%0d.busy", n / 4, g), {31'd0, busy_b}, 32'd1);
                    $display("tb: run2 gap after stage %0d cycle %0d valid=%0d", n / 4, g, valid_b);
                    tick();
                end
            end
        end
        check("run2.done", {31'd0, done_b}, 32'd1);
        check("run2.latency", cyc - t0 + 1, 32'd21);
        $display("tb: run2 done after %0d cycles", cyc - t0 + 1);
        tick();
        check("run2.post.done", {31'd0, done_b}, 32'd0);

        // ---- Run 3: dut_a with 3 stall cycles at stage 1, k=2 ----
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int n = 0; n < 12; n++) begin
            chk_a("run3", n, 1'b0);
            if (n == 6) begin
                ready_a = 1'b0;
                for (int w = 0; w < 3; w++) begin
                    tick();
                    chk_a($sformatf("run3.stall%0d", w), n, 1'b0);
                end
                ready_a = 1'b1;
            end
            tick();
        end
        check("run3.done", {31'd0, done_a}, 32'd1);
        tick();

        // ---- Run 4: asynchronous reset during stage 2, then restart ----
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int n = 0; n < 9; n++) tick();
        chk_a("run4.pre_rst", 9, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk_zero_a("run4.async_rst");
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_zero_a("run4.idle_after_rst");
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk_a("run4.restart", 0, 1'b0);
        for (int n = 0; n < 12; n++) tick();
        check("run4.done", {31'd0, done_a}, 32'd1);
        tick();

`ifdef NTT_INV_EN
        // ---- Run 5: inverse order on dut_a ----
        inv_a   = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        inv_a   = 1'b0;
        for (int n = 0; n < 12; n++) begin
            chk_a("run5_inv", n, 1'b1);
            tick();
        end
        check("run5_inv.done", {31'd0, done_a}, 32'd1);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ntt_addr_gen.md
Name: ntt_addr_gen

Overview:
- Address/twiddle sequencer directly downstream of the NTT Controller.
- On a start pulse (driven from the controller's ntt_enable), walks all LOGN stages of an in-place N-point negative-wrapped NTT.
- For each butterfly, emits one data-memory address pair (addr_a, addr_b) and one twiddle-ROM index, using a valid/ready handshake to the butterfly unit.
- Forward order is Cooley-Tukey: span t halves each stage, twiddle = psi[m+i].

Parameters:
- LOGN, 8, log2 of polynomial length N (N = 2^LOGN, LOGN >= 2).
- STAGE_GAP, 4, idle cycles inserted between stages so the butterfly pipeline drains before the next stage reads (0 allowed).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from controller; ignored unless in IDLE.
- busy  out  1  high from the cycle after start is accepted until done is asserted.
- out_valid  out  1  addr_a/addr_b/tw_idx/stage/last are valid.
- out_ready  in  1  butterfly unit accepts the current butterfly.
- addr_a  out  LOGN  upper-operand address j.
- addr_b  out  LOGN  lower-operand address j+t.
- tw_idx  out  LOGN  twiddle ROM index.
- stage  out  $clog2(LOGN)  current stage s.
- last  out  1  current butterfly is the final one of its stage.
- done  out  1  one-cycle pulse after the final butterfly is accepted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output is 0; internal counters k=0 and s=0.
- States:
  - IDLE: start=1 moves to RUN; k=0, s=0.
  - RUN: out_valid=1. A handshake (out_valid && out_ready) advances k.
    - Last butterfly of a non-final stage accepted: go to GAP, or straight to RUN with s+1 if STAGE_GAP=0.
    - Last butterfly of the final stage accepted: go to DONE.
  - GAP: out_valid=0; counts STAGE_GAP cycles, then RUN with s+1, k=0.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Counters: k runs 0..N/2-1 within a stage; s runs 0..LOGN-1.
- Address math, forward (shift-only; the only adds are addr_b and tw_idx):
  - lt = LOGN-1-s, t = 2^lt, i = k>>lt.
  - addr_a = (i<<(lt+1)) | (k & (t-1)).
  - addr_b = addr_a + t, which never overflows LOGN bits.
  - tw_idx = 2^s + i.
- Outputs are registered. Start sampled at edge 0 gives out_valid=1 with k=0 after edge 0, so the first butterfly is presented in the following cycle.
- Outputs hold stable while out_valid && !out_ready (no change, no drop).
- Throughput: one butterfly per cycle with out_ready held high.
- last=1 exactly when k=N/2-1 and out_valid=1.
- Total cycles from start to done: LOGN*N/2 + (LOGN-1)*STAGE_GAP + 1, assuming no stalls.
- start while busy or in DONE: ignored, with no effect on the sequence.
- Reset mid-sequence: immediate return to IDLE; a partial sequence is never resumed.
- out_ready=1 while out_valid=0: no effect.

Optional Feature:
- Macro: NTT_INV_EN.
- Defined:
  - Adds input port inv (1 bit), latched when start is accepted.
  - inv=1 selects Gentleman-Sande inverse order: lt = s, t = 2^s, i = k>>s, addr_a/addr_b formed as in forward mode, tw_idx = (N>>(s+1)) + i.
  - inv=0 gives forward behaviour.
- Undefined: no inv port; forward order only.

Test Plan:
- LOGN=3, STAGE_GAP=0, out_ready=1, pulse start: three stages of accepted butterflies.
  - Stage 0: (a,b,tw) = (0,4,1), (1,5,1), (2,6,1), (3,7,1).
  - Stage 1: (0,2,2), (1,3,2), (4,6,3), (5,7,3).
  - Stage 2: (0,1,4), (2,3,5), (4,5,6), (6,7,7).
  - last high on the 4th butterfly of each stage; done pulses exactly one cycle after the 12th accept, 13 cycles after start.
- Same run with STAGE_GAP=4: out_valid low for exactly 4 cycles after each of the first two stages; done arrives 8 cycles later than in the first run.
- Backpressure: hold out_ready=0 for 3 cycles on stage 1, k=2: outputs stay (4,6,3,stage=1) the whole time; the sequence resumes unchanged.
- Start pulsed again at stage 1: no effect on outputs and no extra done. Assert rst during stage 2: all outputs 0 asynchronously; a fresh start restarts at (0,4,1).
- NTT_INV_EN defined, LOGN=3, inv=1:
  - Stage 0: (0,1,4), (2,3,5), (4,5,6), (6,7,7).
  - Stage 2: (0,4,1), (1,5,1), (2,6,1), (3,7,1).
- Reset-value check: hold rst=0 for 5 cycles with start=1: busy, out_valid and done stay 0 throughout.
